seven_seg_scanner: RTL and testbench

- Time-multiplexes DIGITS hex digits onto the single 4-bit input of the shared seven-segment decoder and drives the one-hot digit enables of the display.
- Holds a double-buffered display word. New values are committed only at frame boundaries, so a frame never shows a mix of old and new digits.
- Inserts a blanking interval before each digit slot to suppress ghosting. Optionally suppresses leading zeros.

---
 rtl/seven_seg_scanner.sv | 158 +++++++++++++++
 tb/tb_seven_seg_scanner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexes DIGITS hex digits onto one shared seven-segment decoder.
//   The display word is double-buffered. A pending word is committed to the
//   active word only at a frame boundary, so a frame never mixes old and new
//   digits. Each digit slot starts with a blanking interval, and leading
//   zeros can optionally be suppressed.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   load_valid  new display word offered
//   load_ready  pending buffer empty, word can be accepted
//   load_value  digit nibbles, [3:0] = digit 0
//   load_dp     decimal points, bit i = digit i
//   lz_suppress leading-zero suppression enable
//   digit_data  nibble to the decoder
//   dp          decimal point for the current digit
//   digit_sel   one-hot digit enable, active-high
//   blank       1 = segments off
//   frame_done  pulse on the last cycle of digit DIGITS-1
module seven_seg_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 2500,
  parameter int BLANK    = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic                  lz_suppress,
  output logic [3:0]            digit_data,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(DIGITS);

  localparam logic ST_BLANKING = 1'b0;
  localparam logic ST_SHOW     = 1'b1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  state, state_n;

  logic [4*DIGITS-1:0]   act_val, act_val_n;
  logic [DIGITS-1:0]     act_dp, act_dp_n;
  logic [4*DIGITS-1:0]   pend_val;
  logic [DIGITS-1:0]     pend_dp;
  logic                  pend_full, pend_full_n;

  logic                  accept, commit;
  logic [DIGITS-1:0]     sup;
  logic                  nz;
  int unsigned           di;
  int unsigned           sel_i;
  logic                  show;

  logic [3:0]            digit_data_n;
  logic                  dp_n;
  logic [DIGITS-1:0]     digit_sel_n;
  logic                  blank_n;
  logic                  frame_done_n;

  assign accept = load_valid && load_ready;
  // frame_done is high exactly on the last cycle of the frame, so it doubles
  // as the commit strobe; accept needs pending empty, commit needs it full.
  assign commit = frame_done && pend_full;

  always_comb begin
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    if (cnt == CNT_LAST) begin
      cnt_n = '0;
      idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    state_n = state;
    if (cnt_n == '0)
      state_n = ST_BLANKING;
    else if (cnt_n == CNT_BLANK)
      state_n = ST_SHOW;

    act_val_n   = commit ? pend_val : act_val;
    act_dp_n    = commit ? pend_dp  : act_dp;
    pend_full_n = accept ? 1'b1 : (commit ? 1'b0 : pend_full);
  end

  // Walk from the most significant digit down; a digit is suppressible while
  // every digit above it (and itself) is zero with no decimal point.
  always_comb begin
    nz  = 1'b0;
    sup = '0;
    di  = 0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      di      = unsigned'(DIGITS) - 1 - k;
      nz      = nz | (act_val_n[4*di +: 4] != 4'd0) | act_dp_n[di];
      sup[di] = lz_suppress & ~nz & (di != 0);
    end
  end

  // Outputs are registered from next-state values so they line up with the
  // slot counter cycle for cycle.
  always_comb begin
    sel_i        = 32'(idx_n);
    show         = (state_n == ST_SHOW) && !sup[sel_i];
    digit_sel_n  = show ? (DIGITS'(1) << idx_n) : '0;
    blank_n      = !show;
    digit_data_n = show ? act_val_n[4*sel_i +: 4] : 4'd0;
    dp_n         = show ? act_dp_n[sel_i] : 1'b0;
    frame_done_n = (cnt_n == CNT_LAST) && (idx_n == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      state      <= ST_BLANKING;
      act_val    <= '0;
      act_dp     <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_full  <= 1'b0;
      load_ready <= 1'b0;
      digit_sel  <= '0;
      blank      <= 1'b1;
      digit_data <= 4'd0;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      state      <= state_n;
      act_val    <= act_val_n;
      act_dp     <= act_dp_n;
      if (accept) begin
        pend_val <= load_value;
        pend_dp  <= load_dp;
      end
      pend_full  <= pend_full_n;
      load_ready <= !pend_full_n;
      digit_sel  <= digit_sel_n;
      blank      <= blank_n;
      digit_data <= digit_data_n;
      dp         <= dp_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  localparam int D = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [15:0]   load_value = '0;
  logic [3:0]    load_dp = '0;
  logic          lz_suppress = 1'b0;
  logic [3:0]    digit_data;
  logic          dp;
  logic [3:0]    digit_sel;
  logic          blank;
  logic          frame_done;

  seven_seg_scanner #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .load_dp(load_dp),
    .lz_suppress(lz_suppress),
    .digit_data(digit_data), .dp(dp), .digit_sel(digit_sel),
    .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Reference model: time since reset plus the two display buffers.
  int          k = 0;
  logic        mvalid = 1'b0;
  logic [15:0] act_v = '0;
  logic [3:0]  act_d = '0;
  logic [15:0] pv = '0;
  logic [3:0]  pd = '0;
  logic        pf = 1'b0;
  logic        mready = 1'b0;
  logic        lzp = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, act, exp);
  endtask

  always @(negedge clk) begin
    int slot, dig;
    logic [3:0] e_sel, e_dd;
    logic e_blank, e_dp, e_fd, sup;
    slot = k % P;
    dig  = (k / P) % D;
    e_fd = (slot == P - 1) && (dig == D - 1);
    sup  = 1'b0;
    if (lzp && dig > 0) begin
      sup = 1'b1;
      for (int j = dig; j < D; j++)
        if (act_v[j*4 +: 4] != 4'd0 || act_d[j]) sup = 1'b0;
    end
    if (slot < B || sup) begin
      e_sel = 4'd0; e_blank = 1'b1; e_dd = 4'd0; e_dp = 1'b0;
    end else begin
      e_sel = 4'd1 << dig; e_blank = 1'b0; e_dd = act_v[dig*4 +: 4]; e_dp = act_d[dig];
    end
    if (mvalid) begin
      chk("digit_sel",  32'(digit_sel),  32'(e_sel));
      chk("blank",      32'(blank),      32'(e_blank));
      chk("digit_data", 32'(digit_data), 32'(e_dd));
      chk("dp",         32'(dp),         32'(e_dp));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("load_ready", 32'(load_ready), 32'(mready));
    end
    // advance the model across the coming rising edge
    if (rst) begin
      k = 0; act_v = '0; act_d = '0; pf = 1'b0; mready = 1'b0; mvalid = 1'b1;
    end else if (mvalid) begin
      if (load_valid && mready) begin
        pf = 1'b1; pv = load_value; pd = load_dp;
      end else if (e_fd && pf) begin
        act_v = pv; act_d = pd; pf = 1'b0;
      end
      mready = !pf;
      k++;
    end
    lzp = lz_suppress;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic go_to(input int target);
    int n = 0;
    while (k != target && n < 2000) begin step(); n++; end
    if (k != target) begin
      total++;
      $display("FAIL go_to_timeout: k=%0d target=%0d", k, target);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    int n = 0;
    load_value = v; load_dp = d; load_valid = 1'b1;
    while (!load_ready && n < 200) begin step(); n++; end
    if (!load_ready) begin
      total++;
      $display("FAIL load_timeout: load_ready=%0b after %0d cycles, required 1", load_ready, n);
    end
    step();
    load_valid = 1'b0;
  endtask

  function automatic int next_frame();
    return (k / (P * D) + 1) * (P * D);
  endfunction

  initial begin
    int f;
    logic offered;
    logic [15:0] mask;

    repeat (3) step();
    rst = 1'b0;
    // reset cycle (k=0)
    chk("pin_rst_ready", 32'(load_ready), 0);
    chk("pin_rst_blank", 32'(blank), 1);
    step();
    chk("pin_ready_rise", 32'(load_ready), 1);
    go_to(2);
    chk("pin_sel0", 32'(digit_sel), 32'h1);
    go_to(10);
    chk("pin_sel1", 32'(digit_sel), 32'h2);
    go_to(31);
    chk("pin_fd", 32'(frame_done), 1);
    chk("pin_sel3", 32'(digit_sel), 32'h8);
    go_to(32);
    chk("pin_fd_off", 32'(frame_done), 0);

    // mid-frame load of 0x1234 / dp 0100
    go_to(40);
    do_load(16'h1234, 4'b0100);
    chk("pin_ready_drop", 32'(load_ready), 0);
    go_to(50);
    chk("pin_old_frame", 32'(digit_data), 0);
    go_to(64);
    chk("pin_ready_back", 32'(load_ready), 1);
    go_to(66);
    chk("pin_d0_4", 32'(digit_data), 4);
    chk("pin_d0_dp", 32'(dp), 0);
    go_to(82);
    chk("pin_d2_2", 32'(digit_data), 2);
    chk("pin_d2_dp", 32'(dp), 1);

    // second word offered while pending is full
    go_to(84);
    do_load(16'hABCD, 4'b0001);
    do_load(16'h5A5A, 4'b0000);
    go_to(98);
    chk("pin_abcd_d0", 32'(digit_data), 32'hD);
    go_to(122);
    chk("pin_abcd_d3", 32'(digit_data), 32'hA);
    go_to(130);
    chk("pin_5a5a_d0", 32'(digit_data), 32'hA);

    // leading-zero suppression
    lz_suppress = 1'b1;
    do_load(16'h0070, 4'b0000);
    f = next_frame();
    go_to(f + 10);
    chk("pin_lz_d1", 32'(digit_data), 7);
    go_to(f + 18);
    chk("pin_lz_d2_sel", 32'(digit_sel), 0);
    chk("pin_lz_d2_blank", 32'(blank), 1);
    do_load(16'h0000, 4'b0000);
    f = next_frame();
    go_to(f + 2);
    chk("pin_lz0_sel", 32'(digit_sel), 32'h1);
    go_to(f + 10);
    chk("pin_lz0_d1", 32'(digit_sel), 0);
    do_load(16'h0000, 4'b0100);
    f = next_frame();
    go_to(f + 18);
    chk("pin_lzdp_sel", 32'(digit_sel), 32'h4);
    chk("pin_lzdp_dp", 32'(dp), 1);
    go_to(f + 26);
    chk("pin_lzdp_d3", 32'(digit_sel), 0);
    lz_suppress = 1'b0;

    // reset at counter 5 of digit 2 with pending full
    f = next_frame();
    go_to(f + 1);
    do_load(16'h5678, 4'b1111);
    go_to(f + 21);
    rst = 1'b1;
    step();
    chk("pin_mid_rst_ready", 32'(load_ready), 0);
    chk("pin_mid_rst_sel", 32'(digit_sel), 0);
    rst = 1'b0;
    go_to(2);
    chk("pin_after_rst_dd", 32'(digit_data), 0);
    go_to(34);
    chk("pin_discarded", 32'(digit_data), 0);

    // randomized traffic
    offered = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = 1'b0;
      if (offered) load_valid = 1'b0;
      if (!load_valid && $urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: mask = 16'hFFFF;
          1: mask = 16'h00FF;
          2: mask = 16'h000F;
          default: mask = 16'h0000;
        endcase
        load_value = 16'($urandom) & mask;
        load_dp    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
        load_valid = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) lz_suppress = ~lz_suppress;
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      offered = load_valid && load_ready;
    end
    rst = 1'b0;
    load_valid = 1'b0;
    repeat (40) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
